kogge_pipe_adder: RTL

//  Pipelined, handshaked N-bit Kogge-Stone adder; the responder end of the adder stimulus interface.

---
 rtl/kogge_pipe_adder_if.sv | 28 ++
 rtl/kogge_pipe_adder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/kogge_pipe_adder_if.sv
// Operand/result stream interface for the Kogge-Stone pipelined adder.
//   master : operand source / result consumer side (drives in_valid, A, B, Cin, out_ready)
//   slave  : adder side (drives in_ready, out_valid, Sum)
//   in_valid/in_ready   - operand transfer handshake, {Cin, B, A} qualified by in_valid
//   out_valid/out_ready - result transfer handshake, Sum qualified by out_valid
//   Sum is N+1 bits wide; its MSB is the carry out.
interface kogge_pipe_adder_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   Sum;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum
    );
endinterface

// File: rtl/kogge_pipe_adder.sv
// Pipelined, handshaked N-bit Kogge-Stone adder: Sum = A + B + Cin, results
// returned in acceptance order at up to one transfer per cycle.
//
// Ports
//   clk    - rising-edge clock
//   rst_n  - synchronous reset, active-low; discards everything in flight
//   bus    - kogge_pipe_adder_if.slave (operands in, results out, valid/ready on both)
//
// Build option
//   KS_LEVEL_PIPE_EN - when defined, a register stage follows every prefix level
//                      (latency 2+LEVELS edges); otherwise the prefix tree is purely
//                      combinational between the operand and result registers
//                      (latency 2 edges).
//
// The whole pipeline advances on one shared enable, so bubbles travel with the
// data and a stalled output freezes every stage.
module kogge_pipe_adder #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    kogge_pipe_adder_if.slave  bus
);
    localparam int LEVELS = $clog2(N);

    logic en;
    logic out_valid_q;
    logic [N:0] sum_q;

    assign en           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = rst_n & en;
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;

    // stage 0: operand registers
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         cin_q;
    logic         v0_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            v0_q  <= 1'b0;
        end else if (en) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            cin_q <= bus.Cin;
            v0_q  <= bus.in_valid;
        end
    end

    // per-level views: index k is the input to prefix level k, index LEVELS is the final tree output
    logic [N-1:0] g_lv  [0:LEVELS];
    logic [N-1:0] p_lv  [0:LEVELS];
    logic [N-1:0] pb_lv [0:LEVELS];   // bit-level propagate, needed again for the sum bits
    logic         c_lv  [0:LEVELS];
    logic         v_lv  [0:LEVELS];

    logic [N-1:0] pb0;
    assign pb0 = a_q ^ b_q;

    // carry-in enters as a generate into bit 0 so the tree yields true carries directly
    assign g_lv[0]  = (a_q & b_q) | {{(N-1){1'b0}}, pb0[0] & cin_q};
    assign p_lv[0]  = pb0;
    assign pb_lv[0] = pb0;
    assign c_lv[0]  = cin_q;
    assign v_lv[0]  = v0_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int D = 1 << k;

        logic [N-1:0] g_nx;
        logic [N-1:0] p_nx;

        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= D) begin : g_comb
                assign g_nx[i] = g_lv[k][i] | (p_lv[k][i] & g_lv[k][i-D]);
                assign p_nx[i] = p_lv[k][i] & p_lv[k][i-D];
            end else begin : g_pass
                assign g_nx[i] = g_lv[k][i];
                assign p_nx[i] = p_lv[k][i];
            end
        end

`ifdef KS_LEVEL_PIPE_EN
        logic [N-1:0] g_q;
        logic [N-1:0] p_q;
        logic [N-1:0] pb_q;
        logic         c_q;
        logic         v_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                g_q  <= '0;
                p_q  <= '0;
                pb_q <= '0;
                c_q  <= 1'b0;
                v_q  <= 1'b0;
            end else if (en) begin
                g_q  <= g_nx;
                p_q  <= p_nx;
                pb_q <= pb_lv[k];
                c_q  <= c_lv[k];
                v_q  <= v_lv[k];
            end
        end

        assign g_lv[k+1]  = g_q;
        assign p_lv[k+1]  = p_q;
        assign pb_lv[k+1] = pb_q;
        assign c_lv[k+1]  = c_q;
        assign v_lv[k+1]  = v_q;
`else
        assign g_lv[k+1]  = g_nx;
        assign p_lv[k+1]  = p_nx;
        assign pb_lv[k+1] = pb_lv[k];
        assign c_lv[k+1]  = c_lv[k];
        assign v_lv[k+1]  = v_lv[k];
`endif
    end

    // carry into bit i is the group generate of bits [i-1:0]; carry out is G[N-1]
    logic [N-1:0] carry;
    logic [N:0]   sum_d;

    assign carry = {g_lv[LEVELS][N-2:0], c_lv[LEVELS]};
    assign sum_d = {g_lv[LEVELS][N-1], pb_lv[LEVELS] ^ carry};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else if (en) begin
            out_valid_q <= v_lv[LEVELS];
            sum_q       <= sum_d;
        end
    end
endmodule
